// File: rtl/cgra_config_sequencer_pkg.sv
// Shared types, default widths and cycle counts for the CGRA config sequencer.
package cgra_cfg_seq_pkg;

   localparam int DEF_ADDR_W          = 32;
   localparam int DEF_DATA_W          = 32;
   localparam int DEF_SIZE_W          = 16;
   localparam int DEF_FLUSH_STALL_CYC = 8;
   localparam int DEF_FLUSH_RUN_CYC   = 2;
   localparam int DEF_NUM_APPS        = 1;
   localparam int DEF_CNT_W           = 64;
   localparam int DEF_TIMEOUT_W       = 32;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CONFIG,
      ST_GAP,
      ST_FLUSH_STALL,
      ST_FLUSH_RUN,
      ST_RUN,
      ST_FINISH
   } seq_state_e;

   typedef struct packed {
      logic [DEF_ADDR_W-1:0] addr;
      logic [DEF_DATA_W-1:0] data;
   } cfg_word_t;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/cgra_config_sequencer_cycle_tracker.sv
// RUN-phase cycle counter with per-app first-done capture and timeout detect.
module cfg_seq_cycle_tracker
   import cgra_cfg_seq_pkg::*;
#(
   parameter int NUM_APPS  = DEF_NUM_APPS,
   parameter int CNT_W     = DEF_CNT_W,
   parameter int TIMEOUT_W = DEF_TIMEOUT_W
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      clear_i,
   input  logic                      run_i,
   input  logic [NUM_APPS-1:0]       app_done_i,
   input  logic [NUM_APPS-1:0]       done_mask_i,
   input  logic [TIMEOUT_W-1:0]      timeout_lim_i,
   output logic [NUM_APPS*CNT_W-1:0] app_cycles_o,
   output logic                      all_done_o,
   output logic                      timeout_o
);
   localparam int CMP_W = max_int(CNT_W, TIMEOUT_W);

   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic [NUM_APPS-1:0]       seen_q, seen_d;
   logic [NUM_APPS*CNT_W-1:0] cyc_q;

   assign seen_d       = seen_q | (app_done_i & {NUM_APPS{run_i}});
   assign cnt_d        = (!run_i) ? '0 : ((&cnt_q) ? cnt_q : cnt_q + CNT_W'(1));
   // Done is judged on this cycle's flags so the exit follows the last done by one cycle.
   assign all_done_o   = run_i && ((seen_d & done_mask_i) == done_mask_i);
   assign timeout_o    = run_i && (timeout_lim_i != '0) &&
                         (CMP_W'(cnt_q) >= CMP_W'(timeout_lim_i));
   assign app_cycles_o = cyc_q;

   always_ff @(posedge clk) begin
      if (reset || clear_i) begin
         cnt_q  <= '0;
         seen_q <= '0;
         cyc_q  <= '0;
      end else begin
         cnt_q  <= cnt_d;
         seen_q <= seen_d;
         for (int i = 0; i < NUM_APPS; i++) begin
            if (seen_d[i] && !seen_q[i]) cyc_q[i*CNT_W +: CNT_W] <= cnt_q;
         end
      end
   end

endmodule

// File: rtl/cgra_config_sequencer.sv
// Streams {addr,data} config words onto the CGRA bus, runs stall/flush release, then
// monitors app done flags. CFG_READBACK_EN adds per-word readback compare on err.
// States: IDLE wait start | CONFIG stream words | GAP drain write | FLUSH_STALL flush+stall
//         FLUSH_RUN flush only | RUN count/monitor apps | FINISH report, back to IDLE
module cgra_config_sequencer
   import cgra_cfg_seq_pkg::*;
#(
   parameter int ADDR_W          = DEF_ADDR_W,
   parameter int DATA_W          = DEF_DATA_W,
   parameter int SIZE_W          = DEF_SIZE_W,
   parameter int FLUSH_STALL_CYC = DEF_FLUSH_STALL_CYC,
   parameter int FLUSH_RUN_CYC   = DEF_FLUSH_RUN_CYC,
   parameter int NUM_APPS        = DEF_NUM_APPS,
   parameter int CNT_W           = DEF_CNT_W,
   parameter int TIMEOUT_W       = DEF_TIMEOUT_W
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic [SIZE_W-1:0]         bs_size,
   input  logic [TIMEOUT_W-1:0]      timeout_lim,
   input  logic [NUM_APPS-1:0]       done_mask,
   input  logic                      bs_valid,
   output logic                      bs_ready,
   input  logic [ADDR_W-1:0]         bs_addr,
   input  logic [DATA_W-1:0]         bs_data,
   output logic [ADDR_W-1:0]         config_config_addr,
   output logic [DATA_W-1:0]         config_config_data,
   output logic                      config_write,
   output logic                      config_read,
   input  logic [DATA_W-1:0]         config_rdata,
   output logic                      stall,
   output logic                      flush,
   input  logic [NUM_APPS-1:0]       app_done,
   output logic [NUM_APPS*CNT_W-1:0] app_cycles,
   output logic                      busy,
   output logic                      seq_done,
   output logic                      timed_out,
   output logic                      err
);
   localparam int TMR_W = $clog2(max_int(FLUSH_STALL_CYC, FLUSH_RUN_CYC) + 1);

   seq_state_e           state_q;
   logic [TMR_W-1:0]     tmr_q;
   logic [SIZE_W-1:0]    wcnt_q, wcnt_d, size_q;
   logic [TIMEOUT_W-1:0] tlim_q;
   logic [NUM_APPS-1:0]  mask_q;
   logic [ADDR_W-1:0]    addr_q;
   logic [DATA_W-1:0]    data_q;
   logic                 bs_ready_q, write_q, read_q, stall_q, flush_q;
   logic                 busy_q, seq_done_q, timed_out_q, err_q;
   logic                 accept, trk_clear, trk_all_done, trk_timeout;
`ifdef CFG_READBACK_EN
   logic [1:0]           rb_ph_q;
`else
   logic                 unused_rdata;
   assign unused_rdata = ^config_rdata;
`endif

   assign accept    = bs_valid && bs_ready_q;
   assign wcnt_d    = wcnt_q + SIZE_W'(1);
   assign trk_clear = (state_q == ST_IDLE) && start;

   cfg_seq_cycle_tracker #(
      .NUM_APPS  (NUM_APPS),
      .CNT_W     (CNT_W),
      .TIMEOUT_W (TIMEOUT_W)
   ) u_tracker (
      .clk           (clk),
      .reset         (reset),
      .clear_i       (trk_clear),
      .run_i         (state_q == ST_RUN),
      .app_done_i    (app_done),
      .done_mask_i   (mask_q),
      .timeout_lim_i (tlim_q),
      .app_cycles_o  (app_cycles),
      .all_done_o    (trk_all_done),
      .timeout_o     (trk_timeout)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         tmr_q       <= '0;
         wcnt_q      <= '0;
         size_q      <= '0;
         tlim_q      <= '0;
         mask_q      <= '0;
         addr_q      <= '0;
         data_q      <= '0;
         bs_ready_q  <= 1'b0;
         write_q     <= 1'b0;
         read_q      <= 1'b0;
         stall_q     <= 1'b1;
         flush_q     <= 1'b0;
         busy_q      <= 1'b0;
         seq_done_q  <= 1'b0;
         timed_out_q <= 1'b0;
         err_q       <= 1'b0;
`ifdef CFG_READBACK_EN
         rb_ph_q     <= 2'd0;
`endif
      end else begin
         write_q <= 1'b0;
         read_q  <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  size_q      <= bs_size;
                  tlim_q      <= timeout_lim;
                  mask_q      <= done_mask;
                  wcnt_q      <= '0;
                  seq_done_q  <= 1'b0;
                  timed_out_q <= 1'b0;
                  err_q       <= 1'b0;
                  busy_q      <= 1'b1;
`ifdef CFG_READBACK_EN
                  rb_ph_q     <= 2'd0;
`endif
                  if (bs_size == '0) begin
                     state_q <= ST_GAP;
                  end else begin
                     state_q    <= ST_CONFIG;
                     bs_ready_q <= 1'b1;
                  end
               end
            end
            ST_CONFIG: begin
`ifdef CFG_READBACK_EN
               // Phases: 1 = write on bus, 2 = read on bus, 3 = rdata valid for compare.
               case (rb_ph_q)
                  2'd1: begin
                     read_q  <= 1'b1;
                     rb_ph_q <= 2'd2;
                  end
                  2'd2: begin
                     rb_ph_q    <= 2'd3;
                     bs_ready_q <= (wcnt_q != size_q);
                  end
                  2'd3: begin
                     rb_ph_q <= 2'd0;
                     if (config_rdata != data_q) err_q <= 1'b1;
                     if (wcnt_q == size_q) state_q <= ST_GAP;
                  end
                  default: ;
               endcase
               if (accept) begin
                  addr_q     <= bs_addr;
                  data_q     <= bs_data;
                  write_q    <= 1'b1;
                  wcnt_q     <= wcnt_d;
                  bs_ready_q <= 1'b0;
                  rb_ph_q    <= 2'd1;
               end
`else
               if (accept) begin
                  addr_q  <= bs_addr;
                  data_q  <= bs_data;
                  write_q <= 1'b1;
                  wcnt_q  <= wcnt_d;
                  if (wcnt_d == size_q) begin
                     bs_ready_q <= 1'b0;
                     state_q    <= ST_GAP;
                  end
               end
`endif
            end
            ST_GAP: begin
               state_q <= ST_FLUSH_STALL;
               flush_q <= 1'b1;
               tmr_q   <= TMR_W'(FLUSH_STALL_CYC - 1);
            end
            ST_FLUSH_STALL: begin
               if (tmr_q == '0) begin
                  state_q <= ST_FLUSH_RUN;
                  stall_q <= 1'b0;
                  tmr_q   <= TMR_W'(FLUSH_RUN_CYC - 1);
               end else begin
                  tmr_q <= tmr_q - TMR_W'(1);
               end
            end
            ST_FLUSH_RUN: begin
               if (tmr_q == '0) begin
                  state_q <= ST_RUN;
                  flush_q <= 1'b0;
               end else begin
                  tmr_q <= tmr_q - TMR_W'(1);
               end
            end
            ST_RUN: begin
               if (trk_all_done || trk_timeout) begin
                  state_q <= ST_FINISH;
                  stall_q <= 1'b1;
                  busy_q  <= 1'b0;
                  if (trk_all_done) seq_done_q  <= 1'b1;
                  else              timed_out_q <= 1'b1;
               end
            end
            ST_FINISH: state_q <= ST_IDLE;
            default:   state_q <= ST_IDLE;
         endcase
      end
   end

   assign bs_ready           = bs_ready_q;
   assign config_config_addr = addr_q;
   assign config_config_data = data_q;
   assign config_write       = write_q;
   assign config_read        = read_q;
   assign stall              = stall_q;
   assign flush              = flush_q;
   assign busy               = busy_q;
   assign seq_done           = seq_done_q;
   assign timed_out          = timed_out_q;
   assign err                = err_q;

endmodule

// File: tb/tb_cgra_config_sequencer.sv
// Directed bench for cgra_config_sequencer with a config-write scoreboard.
module tb_cgra_config_sequencer;
   import cgra_cfg_seq_pkg::*;

   localparam int NA = 2;
   localparam int CW = DEF_CNT_W;

   logic           clk = 1'b0;
   logic           reset, start, bs_valid, bs_ready;
   logic [15:0]    bs_size;
   logic [31:0]    timeout_lim, bs_addr, bs_data;
   logic [NA-1:0]  done_mask, app_done;
   logic [31:0]    config_config_addr, config_config_data;
   logic [31:0]    config_rdata = '0;
   logic           config_write, config_read, stall, flush;
   logic [NA*CW-1:0] app_cycles;
   logic           busy, seq_done, timed_out, err;

   int total = 0;
   int bad = 0;
   int nwrites = 0;
   cfg_word_t exp_q[$];

   always #5 clk = ~clk;

   cgra_config_sequencer #(.NUM_APPS(NA)) dut (
      .clk                (clk),
      .reset              (reset),
      .start              (start),
      .bs_size            (bs_size),
      .timeout_lim        (timeout_lim),
      .done_mask          (done_mask),
      .bs_valid           (bs_valid),
      .bs_ready           (bs_ready),
      .bs_addr            (bs_addr),
      .bs_data            (bs_data),
      .config_config_addr (config_config_addr),
      .config_config_data (config_config_data),
      .config_write       (config_write),
      .config_read        (config_read),
      .config_rdata       (config_rdata),
      .stall              (stall),
      .flush              (flush),
      .app_done           (app_done),
      .app_cycles         (app_cycles),
      .busy               (busy),
      .seq_done           (seq_done),
      .timed_out          (timed_out),
      .err                (err)
   );

`ifdef CFG_READBACK_EN
   // Array model: returns written data one cycle after a read, corrupting address 0x204.
   always @(posedge clk) begin
      if (config_read === 1'b1)
         config_rdata <= (config_config_addr == 32'h204) ? ~config_config_data : config_config_data;
   end
`endif

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (config_write === 1'b1) begin
         cfg_word_t w;
         nwrites++;
         chk("wr_expected", exp_q.size() != 0, 1);
         if (exp_q.size() != 0) begin
            w = exp_q.pop_front();
            chk("wr_addr", config_config_addr, w.addr);
            chk("wr_data", config_config_data, w.data);
         end
      end
   end

   task automatic check_reset(input string tag);
      chk({tag, "_stall"}, stall, 1);
      chk({tag, "_flush"}, flush, 0);
      chk({tag, "_write"}, config_write, 0);
      chk({tag, "_read"}, config_read, 0);
      chk({tag, "_addr"}, config_config_addr, 0);
      chk({tag, "_data"}, config_config_data, 0);
      chk({tag, "_ready"}, bs_ready, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_seq_done"}, seq_done, 0);
      chk({tag, "_timed_out"}, timed_out, 0);
      chk({tag, "_err"}, err, 0);
      chk({tag, "_app_cycles"}, app_cycles, 0);
   endtask

   task automatic start_seq(input logic [15:0] sz, input logic [31:0] lim, input logic [NA-1:0] m);
      bs_size = sz;
      timeout_lim = lim;
      done_mask = m;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send(input logic [31:0] a, input logic [31:0] d);
      int n = 0;
      cfg_word_t w;
      while (bs_ready !== 1'b1 && n < 20) begin
         bs_valid = 1'b0;
         @(negedge clk);
         n++;
      end
      chk("send_budget", n < 20, 1);
      bs_valid = 1'b1;
      bs_addr = a;
      bs_data = d;
      w.addr = a;
      w.data = d;
      exp_q.push_back(w);
      @(negedge clk);
   endtask

   task automatic wait_end(input int budget);
      int n = 0;
      while (!(seq_done === 1'b1 || timed_out === 1'b1) && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk("wait_budget", n < budget, 1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; start = 1'b0; bs_size = '0; timeout_lim = '0; done_mask = '0;
      bs_valid = 1'b0; bs_addr = '0; bs_data = '0; app_done = '0;
      repeat (3) @(negedge clk);
      check_reset("rst");
      reset = 1'b0;
      @(negedge clk);

      // Three-word stream, empty mask
      start_seq(16'd3, 32'd0, 2'b00);
      chk("t1_busy", busy, 1);
      chk("t1_ready", bs_ready, 1);
      send(32'h100, 32'hA);
`ifndef CFG_READBACK_EN
      chk("t1_b2b_w0", config_write, 1);
`endif
      send(32'h104, 32'hB);
`ifndef CFG_READBACK_EN
      chk("t1_b2b_w1", config_write, 1);
`endif
      send(32'h108, 32'hC);
`ifndef CFG_READBACK_EN
      chk("t1_b2b_w2", config_write, 1);
`endif
      chk("t1_ready_low", bs_ready, 0);
      bs_valid = 1'b1; bs_addr = 32'h10C; bs_data = 32'hD;
      repeat (2) begin
         @(negedge clk);
         chk("t1_extra_ready", bs_ready, 0);
      end
      bs_valid = 1'b0;
      wait_end(100);
      chk("t1_seq_done", seq_done, 1);
      chk("t1_timed_out", timed_out, 0);
      chk("t1_busy_fin", busy, 0);
      chk("t1_stall_fin", stall, 1);
      chk("t1_nwrites", nwrites, 3);
      chk("t1_q_empty", exp_q.size(), 0);
      chk("t1_err", err, 0);
      @(negedge clk);
      chk("t1_held", seq_done, 1);

      // Empty bitstream: flush/stall release timing, RUN on cycle 12
      start_seq(16'd0, 32'd0, 2'b00);
      for (int k = 1; k <= 14; k++) begin
         chk("t2_flush", flush, (k >= 2 && k <= 11));
         chk("t2_stall", stall, !(k >= 10 && k <= 12));
         chk("t2_seq_done", seq_done, k >= 13);
         chk("t2_busy", busy, k <= 12);
         if (k < 14) @(negedge clk);
      end
      chk("t2_nwrites", nwrites, 3);

      // Two apps: done at run cycles 5 and 9, re-toggle of app 0 ignored
      start_seq(16'd0, 32'd0, 2'b11);
      repeat (16) @(negedge clk);
      app_done = 2'b01;
      @(negedge clk);
      app_done = 2'b00;
      chk("t3_cyc_partial", app_cycles, {64'd0, 64'd5});
      @(negedge clk);
      app_done = 2'b01;
      @(negedge clk);
      app_done = 2'b00;
      @(negedge clk);
      chk("t3_not_done", seq_done, 0);
      app_done = 2'b10;
      @(negedge clk);
      app_done = 2'b00;
      chk("t3_seq_done", seq_done, 1);
      chk("t3_cycles", app_cycles, {64'd9, 64'd5});
      chk("t3_timed_out", timed_out, 0);
      chk("t3_busy", busy, 0);
      @(negedge clk);

      // Timeout at run count 20 with app never done
      start_seq(16'd0, 32'd20, 2'b01);
      repeat (31) @(negedge clk);
      chk("t4_pre_to", timed_out, 0);
      chk("t4_pre_stall", stall, 0);
      chk("t4_pre_busy", busy, 1);
      @(negedge clk);
      chk("t4_timed_out", timed_out, 1);
      chk("t4_seq_done", seq_done, 0);
      chk("t4_stall", stall, 1);
      chk("t4_cycles_clr", app_cycles, 0);
      @(negedge clk);

      // Done and timeout on the same cycle: done wins
      start_seq(16'd0, 32'd6, 2'b01);
      repeat (17) @(negedge clk);
      chk("t5_pre", seq_done | timed_out, 0);
      app_done = 2'b01;
      @(negedge clk);
      app_done = 2'b00;
      chk("t5_seq_done", seq_done, 1);
      chk("t5_timed_out", timed_out, 0);
      chk("t5_cycles", app_cycles, {64'd0, 64'd6});
      @(negedge clk);

      // Reset after 1 of 4 words, then a clean restart
      start_seq(16'd4, 32'd0, 2'b00);
      send(32'h300, 32'h1);
      bs_valid = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      check_reset("mid_rst");
      reset = 1'b0;
      @(negedge clk);
      start_seq(16'd2, 32'd0, 2'b00);
      send(32'h400, 32'h11);
      send(32'h404, 32'h22);
      bs_valid = 1'b0;
      wait_end(100);
      chk("t6_seq_done", seq_done, 1);
      chk("t6_q_empty", exp_q.size(), 0);
      chk("t6_nwrites", nwrites, 6);
      @(negedge clk);

`ifdef CFG_READBACK_EN
      start_seq(16'd3, 32'd0, 2'b00);
      send(32'h200, 32'h5);
      send(32'h204, 32'h6);
      send(32'h208, 32'h7);
      bs_valid = 1'b0;
      wait_end(200);
      chk("rb_err", err, 1);
      chk("rb_seq_done", seq_done, 1);
      chk("rb_nwrites", nwrites, 9);
`else
      chk("err_tied", err, 0);
      chk("read_tied", config_read, 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
